// File: rtl/eth_pio_in.sv
// Avalon-MM parallel-input port: synchronized, edge-captured status pins with a maskable level irq.
// Optional per-pin debounce filter is compiled in with `define PIO_IN_DEBOUNCE_EN.
module eth_pio_in #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1, sync2, filt, filt_d;
  logic [WIDTH-1:0] irqmask, edgecap;
  logic [WIDTH-1:0] rise, fall, ev, clr;
  logic             wr_stb;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign wr_stb = chipselect & ~write_n;
  // Write bits above WIDTH are deliberately ignored.
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  logic [15:0] db_cnt [WIDTH];

  // A pin must disagree with filt for DEBOUNCE_CYCLES consecutive samples to be accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          filt[i]   <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) filt <= '0;
    else          filt <= sync2;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) filt_d <= '0;
    else          filt_d <= filt;
  end

  assign rise = filt & ~filt_d;
  assign fall = ~filt & filt_d;

  always_comb begin
    ev = rise | fall;
    case (EDGE_TYPE)
      0:       ev = rise;
      1:       ev = fall;
      default: ev = rise | fall;
    endcase
  end

  always_comb begin
    clr = '0;
    if (wr_stb && address == 2'd3) clr = writedata[WIDTH-1:0];
  end

  // A new edge wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edgecap <= '0;
    else          edgecap <= ev | (edgecap & ~clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          irqmask <= '0;
    else if (wr_stb && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = filt;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecap;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_eth_pio_in.sv
// Bench for eth_pio_in: three instances (rising/falling/any edge) against a history-based model.
module tb_eth_pio_in;

  localparam int DC = 16;
`ifdef PIO_IN_DEBOUNCE_EN
  localparam int LAT = DC + 2;
  localparam bit DB  = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit DB  = 1'b0;
`endif
  localparam int SETTLE = LAT + 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = 4'hF;
  logic [31:0] rdd [3];
  logic        irq [3];
  logic [31:0] got [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  eth_pio_in #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DC)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdd[0]), .irq(irq[0]));
  eth_pio_in #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(DC)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdd[1]), .irq(irq[1]));
  eth_pio_in #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DC)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdd[2]), .irq(irq[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: filtered value is the pin sampled two edges earlier (or after a stable run when debounced).
  logic [3:0]  hist [$];
  logic [3:0]  m_filt = '0, m_filt_d = '0, m_mask = '0;
  logic [3:0]  m_cap [3] = '{default: '0};
  logic [31:0] m_rd  [3] = '{default: '0};
  int          run   [4] = '{default: 0};

  initial begin
    logic [3:0] s, ev, clr;
    logic       stb;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        hist.delete();
        m_filt = '0; m_filt_d = '0; m_mask = '0;
        for (int t = 0; t < 3; t++) begin m_cap[t] = '0; m_rd[t] = '0; end
        for (int i = 0; i < 4; i++) run[i] = 0;
      end else begin
        hist.push_back(in_port);
        if (hist.size() > 3) void'(hist.pop_front());
        s   = (hist.size() == 3) ? hist[0] : 4'h0;
        stb = chipselect && !write_n;
        clr = (stb && address == 2'd3) ? writedata[3:0] : 4'h0;
        for (int t = 0; t < 3; t++) begin
          case (address)
            2'd0:    m_rd[t] = {28'd0, m_filt};
            2'd2:    m_rd[t] = {28'd0, m_mask};
            2'd3:    m_rd[t] = {28'd0, m_cap[t]};
            default: m_rd[t] = 32'd0;
          endcase
          if (t == 0)      ev = m_filt & ~m_filt_d;
          else if (t == 1) ev = ~m_filt & m_filt_d;
          else             ev = m_filt ^ m_filt_d;
          m_cap[t] = ev | (m_cap[t] & ~clr);
        end
        if (stb && address == 2'd2) m_mask = writedata[3:0];
        m_filt_d = m_filt;
        if (DB) begin
          for (int i = 0; i < 4; i++) begin
            if (s[i] != m_filt[i]) begin
              run[i]++;
              if (run[i] == DC) begin m_filt[i] = s[i]; run[i] = 0; end
            end else begin
              run[i] = 0;
            end
          end
        end else begin
          m_filt = s;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int t = 0; t < 3; t++) begin
        chk($sformatf("model_rd_u%0d", t), rdd[t], m_rd[t]);
        chk($sformatf("model_irq_u%0d", t), {31'd0, irq[t]}, {31'd0, |(m_cap[t] & m_mask)});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    @(posedge clk);
    #1;
    for (int t = 0; t < 3; t++) got[t] = rdd[t];
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #2;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3;
    chk("reset_rd", rdd[0], 32'h0);
    chk("reset_irq", {31'd0, irq[0]}, 32'h0);
    @(posedge clk); #2;
    reset_n = 1'b1;

    // Pins high through reset: rising/any capture all, falling none.
    tick(SETTLE);
    chk("post_reset_irq", {31'd0, irq[0]}, 32'h0);
    rd(2'd3);
    chk("post_reset_cap_u0", got[0], 32'hF);
    chk("post_reset_cap_u1", got[1], 32'h0);
    chk("post_reset_cap_u2", got[2], 32'hF);
    in_port = 4'h0;
    tick(SETTLE);
    rd(2'd3);
    chk("fall_all_u1", got[1], 32'hF);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3);
    chk("clear_all_u0", got[0], 32'h0);

    // Masked edge on pin 1.
    wr(2'd2, 32'h2);
    in_port = 4'h2;
    tick(LAT);
    chk("irq_before_lat", {31'd0, irq[0]}, 32'h0);
    tick(1);
    chk("irq_at_lat", {31'd0, irq[0]}, 32'h1);
    rd(2'd3);
    chk("cap_pin1", got[0], 32'h2);
    rd(2'd0);
    chk("data_pin1", got[0], 32'h2);
    in_port = 4'h0;
    tick(SETTLE);
    wr(2'd3, 32'h2);
    chk("irq_cleared", {31'd0, irq[0]}, 32'h0);
    wr(2'd3, 32'hFFFF_FFFF);

    // Clear lands on the same edge that sets the bit.
    wr(2'd2, 32'h1);
    in_port = 4'h1;
    tick(LAT);
    wr(2'd3, 32'h1);
    chk("set_clr_irq", {31'd0, irq[0]}, 32'h1);
    rd(2'd3);
    chk("set_clr_cap", got[0], 32'h1);
    in_port = 4'h0;
    tick(SETTLE);
    wr(2'd3, 32'hFFFF_FFFF);

    // Reserved word and upper mask bits.
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd1);
    chk("reserved_rd", got[0], 32'h0);
    rd(2'd2);
    chk("mask_width", got[0], 32'hF);

    // Pin 3 toggle across edge types, with a clear between transitions.
    wr(2'd3, 32'hFFFF_FFFF);
    in_port = 4'h8;
    tick(SETTLE);
    rd(2'd3);
    chk("p3_rise_u0", got[0], 32'h8);
    chk("p3_rise_u1", got[1], 32'h0);
    chk("p3_rise_u2", got[2], 32'h8);
    wr(2'd3, 32'h8);
    in_port = 4'h0;
    tick(SETTLE);
    rd(2'd3);
    chk("p3_fall_u0", got[0], 32'h0);
    chk("p3_fall_u1", got[1], 32'h8);
    chk("p3_fall_u2", got[2], 32'h8);
    wr(2'd3, 32'hFFFF_FFFF);

    // 10-cycle glitch on pin 0.
    in_port = 4'h1;
    tick(8);
    rd(2'd0);
    chk("glitch_data", got[0], DB ? 32'h0 : 32'h1);
    tick(1);
    in_port = 4'h0;
    tick(SETTLE);
    rd(2'd3);
    chk("glitch_cap", got[0], DB ? 32'h0 : 32'h1);
    wr(2'd3, 32'hFFFF_FFFF);

    // 20-cycle level on pin 0.
    in_port = 4'h1;
    tick(LAT);
    chk("level_irq_early", {31'd0, irq[0]}, 32'h0);
    tick(1);
    chk("level_irq", {31'd0, irq[0]}, 32'h1);
    tick(20 - LAT - 1);
    rd(2'd0);
    chk("level_data", got[0], 32'h1);

    // Asynchronous reset mid-cycle drops the pending interrupt immediately.
    reset_n = 1'b0;
    #1;
    chk("async_rst_irq", {31'd0, irq[0]}, 32'h0);
    chk("async_rst_rd", rdd[0], 32'h0);
    tick(2);
    reset_n = 1'b1;
    in_port = 4'h0;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
